// File: rtl/top_pkg.sv
// Shared types and helpers for the top_fc fully-connected layer engine.
// Holds the FSM state encoding, tile/accumulator constants and the saturation helper.
package top_pkg;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int TILE  = 8;
    localparam int WBYTE = 8;
    localparam int ACC_W = 32;

    // Clamp a signed accumulator to the signed range of a w-bit result.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [ACC_W-1:0] v,
                                                    input int unsigned w);
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        hi = (32'sd1 <<< (w - 32'd1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/ifm_buffer.sv
// Activation buffer for top_fc: N x IFM_WIDTH register array, one write port
// and one combinational read port. Contents are deliberately not reset.
module ifm_buffer
    import top_pkg::*;
#(
    parameter int DEPTH  = 100,
    parameter int WIDTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] fifo_data [DEPTH];

    // Write port: capture one activation per accepted word.
    always_ff @(posedge clk1) begin
        if (wr_en) begin
            fifo_data[wr_addr] <= wr_data;
        end
    end

    assign rd_data = fifo_data[rd_addr];

endmodule

// File: rtl/top_fc.sv
// Fully-connected layer: loads an N-word activation vector, then streams M/8 weight
// tiles through eight signed MACs and drains eight saturated results per tile.
// Optional macro TOP_RELU_EN forces negative saturated results to zero.
module top_fc
    import top_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int IFM_WIDTH   = 16,
    parameter int WGT_WIDTH   = 16,
    parameter int IFM_SIZE    = 100,
    parameter int TILING_SIZE = 8,
    parameter int KERNEL_SIZE = 8000
) (
    input  logic                  clk1,
    input  logic                  rst_n,
    input  logic [IFM_WIDTH-1:0]  ifm,
    input  logic                  valid_ifm,
    input  logic [63:0]           wgt,
    output logic                  ifm_read,
    output logic                  wgt_read,
    output logic [DATA_WIDTH-1:0] ofm,
    output logic                  valid_data
);

    localparam int N      = IFM_SIZE;
    localparam int M      = KERNEL_SIZE / IFM_SIZE;
    localparam int TILES  = M / TILING_SIZE;
    localparam int ADDR_W = $clog2(N);
    localparam int CNT_W  = ($clog2(N + 1) > 4) ? $clog2(N + 1) : 4;
    localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;

    if ((TILING_SIZE != TILE) || (WGT_WIDTH < WBYTE)) begin : g_bad_cfg
        $error("top_fc: unsupported TILING_SIZE or WGT_WIDTH");
    end

    state_t                  state_r;
    state_t                  state_s;
    logic [CNT_W-1:0]        cnt_r;
    logic [CNT_W-1:0]        wr_idx_r;
    logic [TILE_W-1:0]       tile_r;
    logic signed [ACC_W-1:0] acc_r [TILE];
    logic signed [ACC_W-1:0] acc_s [TILE];
    logic signed [ACC_W-1:0] ifm_ext_s;
    logic signed [ACC_W-1:0] sel_s;
    logic signed [ACC_W-1:0] sat_s;
    logic [DATA_WIDTH-1:0]   ofm_s;
    logic [IFM_WIDTH-1:0]    rd_data_s;
    logic [DATA_WIDTH-1:0]   ofm_r;
    logic                    valid_r;
    logic                    ifm_read_r;
    logic                    wgt_read_r;
    logic                    last_cmp_s;
    logic                    last_drn_s;
    logic                    last_tile_s;

    ifm_buffer #(
        .DEPTH  (N),
        .WIDTH  (IFM_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_ifm_buffer (
        .clk1    (clk1),
        .wr_en   ((state_r == LOAD) && valid_ifm),
        .wr_addr (wr_idx_r[ADDR_W-1:0]),
        .wr_data (ifm),
        .rd_addr (cnt_r[ADDR_W-1:0]),
        .rd_data (rd_data_s)
    );

    assign last_cmp_s  = (cnt_r == CNT_W'(N - 1));
    assign last_drn_s  = (cnt_r == CNT_W'(TILE - 1));
    assign last_tile_s = (tile_r == TILE_W'(TILES - 1));
    assign ifm_ext_s   = $signed({{(ACC_W-IFM_WIDTH){rd_data_s[IFM_WIDTH-1]}}, rd_data_s});

    // Next-state decode for the LOAD -> COMPUTE -> DRAIN sequence.
    always_comb begin
        state_s = state_r;
        case (state_r)
            LOAD: begin
                if (valid_ifm && (wr_idx_r == CNT_W'(N - 1))) begin
                    state_s = COMPUTE;
                end else begin
                    state_s = LOAD;
                end
            end
            COMPUTE: begin
                if (last_cmp_s) begin
                    state_s = DRAIN;
                end else begin
                    state_s = COMPUTE;
                end
            end
            DRAIN: begin
                if (last_drn_s) begin
                    state_s = last_tile_s ? LOAD : COMPUTE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: state_s = LOAD;
        endcase
    end

    // Eight signed MAC lanes; the first cycle of a tile starts from zero.
    always_comb begin
        for (int k = 0; k < TILE; k++) begin
            acc_s[k] = ((cnt_r == {CNT_W{1'b0}}) ? {ACC_W{1'b0}} : acc_r[k])
                     + ifm_ext_s * $signed({{(ACC_W-WBYTE){wgt[k*WBYTE+WBYTE-1]}},
                                            wgt[k*WBYTE +: WBYTE]});
        end
    end

    // Result for the next output beat: lane 0 straight from the final MAC, later lanes from acc_r.
    always_comb begin
        if (state_r == DRAIN) begin
            sel_s = acc_r[cnt_r[2:0] + 3'd1];
        end else begin
            sel_s = acc_s[0];
        end
        sat_s = sat(sel_s, DATA_WIDTH);
`ifdef TOP_RELU_EN
        if (sat_s < 32'sd0) begin
            ofm_s = {DATA_WIDTH{1'b0}};
        end else begin
            ofm_s = sat_s[DATA_WIDTH-1:0];
        end
`else
        ofm_s = sat_s[DATA_WIDTH-1:0];
`endif
    end

    // State, counters, accumulators and registered handshake/result outputs.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= LOAD;
            cnt_r      <= {CNT_W{1'b0}};
            wr_idx_r   <= {CNT_W{1'b0}};
            tile_r     <= {TILE_W{1'b0}};
            ofm_r      <= {DATA_WIDTH{1'b0}};
            valid_r    <= 1'b0;
            ifm_read_r <= 1'b1;
            wgt_read_r <= 1'b0;
            for (int k = 0; k < TILE; k++) begin
                acc_r[k] <= {ACC_W{1'b0}};
            end
        end else begin
            state_r    <= state_s;
            ifm_read_r <= (state_s == LOAD);
            wgt_read_r <= (state_s == COMPUTE);
            valid_r    <= (state_s == DRAIN);
            ofm_r      <= (state_s == DRAIN) ? ofm_s : {DATA_WIDTH{1'b0}};
            case (state_r)
                LOAD: begin
                    cnt_r <= {CNT_W{1'b0}};
                    if (valid_ifm) begin
                        wr_idx_r <= wr_idx_r + CNT_W'(1);
                    end
                end
                COMPUTE: begin
                    cnt_r <= last_cmp_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
                    for (int k = 0; k < TILE; k++) begin
                        acc_r[k] <= acc_s[k];
                    end
                end
                DRAIN: begin
                    cnt_r <= last_drn_s ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
                    if (last_drn_s && last_tile_s) begin
                        tile_r   <= {TILE_W{1'b0}};
                        wr_idx_r <= {CNT_W{1'b0}};
                    end else if (last_drn_s) begin
                        tile_r <= tile_r + TILE_W'(1);
                    end
                end
                default: begin
                    cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign ifm_read   = ifm_read_r;
    assign wgt_read   = wgt_read_r;
    assign valid_data = valid_r;
    assign ofm        = ofm_r;

endmodule

// File: tb/tb_top_fc.sv
// Self-checking bench for top_fc (N=100, M=80): randomized vectors and weights
// compared against a dot-product/saturation reference model.
module tb_top_fc;

    localparam int N     = 100;
    localparam int M     = 80;
    localparam int TILES = M / 8;
    localparam int BEATS = N * TILES;

    logic               clk1 = 1'b0;
    logic               rst_n;
    logic signed [15:0] ifm;
    logic               valid_ifm;
    logic [63:0]        wgt;
    logic               ifm_read;
    logic               wgt_read;
    logic signed [15:0] ofm;
    logic               valid_data;

    always #5 clk1 = ~clk1;

    top_fc #(
        .DATA_WIDTH (16), .IFM_WIDTH (16), .WGT_WIDTH (16),
        .IFM_SIZE (N), .TILING_SIZE (8), .KERNEL_SIZE (N * M)
    ) dut (
        .clk1 (clk1), .rst_n (rst_n), .ifm (ifm), .valid_ifm (valid_ifm), .wgt (wgt),
        .ifm_read (ifm_read), .wgt_read (wgt_read), .ofm (ofm), .valid_data (valid_data)
    );

    int checks   = 0;
    int failures = 0;

    logic signed [15:0] vec  [N];
    logic [63:0]        wmem [BEATS];
    int                 exp_out [M];
    int                 outs [$];
    int                 prev [$];
    int                 seq_err;
    int                 zero_err;
    bit                 timed_out;
    bit                 aborted;

    // Reference: neuron j = sat(sum_i vec[i] * weight(j, i)), weight from tile j/8, byte j%8.
    function automatic void build_model();
        for (int j = 0; j < M; j++) begin
            longint s;
            logic signed [7:0] wb;
            s = 0;
            for (int i = 0; i < N; i++) begin
                wb = wmem[(j / 8) * N + i][8 * (j % 8) +: 8];
                s += longint'(vec[i]) * longint'(wb);
            end
            if (s > 32767) s = 32767;
            if (s < -32768) s = -32768;
`ifdef TOP_RELU_EN
            if (s < 0) s = 0;
`endif
            exp_out[j] = int'(s);
        end
    endfunction

    function automatic void fill_random();
        for (int i = 0; i < N; i++) vec[i] = 16'($urandom);
        for (int b = 0; b < BEATS; b++) wmem[b] = {$urandom, $urandom};
    endfunction

    function automatic void fill_weights(input logic [7:0] w);
        for (int b = 0; b < BEATS; b++) wmem[b] = {8{w}};
    endfunction

    // Drives one full vector and weight stream, recording outputs and protocol deviations.
    task automatic run_vector(input int gap_pos, input int gap_len, input bit poke, input int abort_at);
        int idx, wbeat, cyc, c_last, o;
        logic [2:0] exp_b;
        bit done;
        idx = 0; wbeat = 0; cyc = 0; c_last = -1;
        outs.delete();
        seq_err = 0; zero_err = 0; timed_out = 1'b0; aborted = 1'b0;
        forever begin
            @(negedge clk1);
            done = 1'b0;
            if (c_last < 0 || cyc <= c_last) begin
                exp_b = 3'b100;
            end else begin
                o = cyc - c_last - 1;
                if (o >= TILES * (N + 8)) begin
                    exp_b = 3'b100;
                    done  = 1'b1;
                end else if ((o % (N + 8)) < N) begin
                    exp_b = 3'b010;
                end else begin
                    exp_b = 3'b001;
                end
            end
            if ({ifm_read, wgt_read, valid_data} !== exp_b) seq_err++;
            if (valid_data !== 1'b1 && ofm !== 16'sd0) zero_err++;
            if (valid_data === 1'b1) outs.push_back(int'(ofm));
            if (done) begin
                valid_ifm = 1'b0;
                return;
            end
            if (abort_at >= 0 && outs.size() == abort_at) begin
                aborted   = 1'b1;
                valid_ifm = 1'b0;
                return;
            end
            if (ifm_read === 1'b1 && c_last < 0) begin
                if (cyc >= gap_pos && cyc < gap_pos + gap_len) begin
                    valid_ifm = 1'b0;
                    ifm       = 16'($urandom);
                end else begin
                    valid_ifm = 1'b1;
                    ifm       = vec[idx];
                    if (idx == N - 1) c_last = cyc;
                    idx++;
                end
            end else begin
                valid_ifm = poke;
                ifm       = 16'sd7;
            end
            if (wgt_read === 1'b1 && wbeat < BEATS) begin
                wgt = wmem[wbeat];
                wbeat++;
            end else begin
                wgt = {$urandom, $urandom};
            end
            cyc++;
            if (cyc > 5000) begin
                timed_out = 1'b1;
                valid_ifm = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; valid_ifm = 1'b0; ifm = 16'sd0; wgt = 64'd0;
        repeat (3) @(negedge clk1);
        checks++; if (valid_data !== 1'b0 || wgt_read !== 1'b0 || ofm !== 16'sd0) begin
            failures++; $display("FAIL reset_hold: valid=%b wgt_read=%b ofm=%0d, want 0/0/0", valid_data, wgt_read, ofm);
        end
        rst_n = 1'b1;
        @(negedge clk1);
        checks++; if (ifm_read !== 1'b1) begin
            failures++; $display("FAIL reset_ifm_read: got %b want 1", ifm_read);
        end
        checks++; if (wgt_read !== 1'b0 || valid_data !== 1'b0 || ofm !== 16'sd0) begin
            failures++; $display("FAIL reset_idle: wgt_read=%b valid=%b ofm=%0d want 0/0/0", wgt_read, valid_data, ofm);
        end
    endtask

    task automatic test_directed_sum();
        for (int i = 0; i < N; i++) vec[i] = (i < 4) ? 16'(i + 1) : 16'sd0;
        fill_weights(8'sd1);
        run_vector(N, 0, 1'b0, -1);
        checks++; if (timed_out || seq_err != 0 || zero_err != 0) begin
            failures++; $display("FAIL sum_protocol: timeout=%0d seq_err=%0d zero_err=%0d want 0/0/0", timed_out, seq_err, zero_err);
        end
        checks++; if (outs.size() != M) begin
            failures++; $display("FAIL sum_count: got %0d outputs want %0d", outs.size(), M);
        end
        for (int j = 0; j < outs.size() && j < M; j++) begin
            checks++; if (outs[j] != 10) begin
                failures++; $display("FAIL sum_value[%0d]: got %0d want 10", j, outs[j]);
            end
        end
    endtask

    task automatic test_saturation();
        int want;
        for (int i = 0; i < N; i++) vec[i] = (i < 4) ? 16'sd1000 : 16'sd0;
        for (int pass = 0; pass < 2; pass++) begin
            fill_weights(pass == 0 ? 8'h7f : 8'h80);
`ifdef TOP_RELU_EN
            want = (pass == 0) ? 32767 : 0;
`else
            want = (pass == 0) ? 32767 : -32768;
`endif
            run_vector(N, 0, 1'b0, -1);
            checks++; if (timed_out || seq_err != 0 || outs.size() != M) begin
                failures++; $display("FAIL sat_protocol[%0d]: timeout=%0d seq_err=%0d outputs=%0d want 0/0/%0d", pass, timed_out, seq_err, outs.size(), M);
            end
            for (int j = 0; j < outs.size() && j < M; j += 9) begin
                checks++; if (outs[j] != want) begin
                    failures++; $display("FAIL sat_value[%0d][%0d]: got %0d want %0d", pass, j, outs[j], want);
                end
            end
        end
    endtask

    task automatic test_gapped_random();
        fill_random();
        build_model();
        run_vector(50, 10, 1'b0, -1);
        checks++; if (timed_out || seq_err != 0 || zero_err != 0 || outs.size() != M) begin
            failures++; $display("FAIL gap_protocol: timeout=%0d seq_err=%0d zero_err=%0d outputs=%0d want 0/0/0/%0d", timed_out, seq_err, zero_err, outs.size(), M);
        end
        for (int j = 0; j < outs.size() && j < M; j++) begin
            checks++; if (outs[j] != exp_out[j]) begin
                failures++; $display("FAIL gap_value[%0d]: got %0d want %0d", j, outs[j], exp_out[j]);
            end
        end
        prev = outs;
    endtask

    task automatic test_ignore_during_compute();
        run_vector(N, 0, 1'b1, -1);
        checks++; if (timed_out || seq_err != 0 || outs.size() != M) begin
            failures++; $display("FAIL poke_protocol: timeout=%0d seq_err=%0d outputs=%0d want 0/0/%0d", timed_out, seq_err, outs.size(), M);
        end
        for (int j = 0; j < outs.size() && j < M && j < prev.size(); j++) begin
            checks++; if (outs[j] != exp_out[j] || outs[j] != prev[j]) begin
                failures++; $display("FAIL poke_value[%0d]: got %0d want %0d", j, outs[j], exp_out[j]);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        fill_random();
        run_vector(N, 0, 1'b0, 3);
        checks++; if (aborted !== 1'b1) begin
            failures++; $display("FAIL drain_reached: got %0d want 1", aborted);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (valid_data !== 1'b0 || ofm !== 16'sd0 || wgt_read !== 1'b0) begin
            failures++; $display("FAIL drain_reset: valid=%b ofm=%0d wgt_read=%b want 0/0/0", valid_data, ofm, wgt_read);
        end
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);
        checks++; if (ifm_read !== 1'b1 || valid_data !== 1'b0) begin
            failures++; $display("FAIL drain_release: ifm_read=%b valid=%b want 1/0", ifm_read, valid_data);
        end
        fill_random();
        build_model();
        run_vector(N, 0, 1'b0, -1);
        checks++; if (timed_out || seq_err != 0 || outs.size() != M) begin
            failures++; $display("FAIL fresh_protocol: timeout=%0d seq_err=%0d outputs=%0d want 0/0/%0d", timed_out, seq_err, outs.size(), M);
        end
        for (int j = 0; j < outs.size() && j < M; j++) begin
            checks++; if (outs[j] != exp_out[j]) begin
                failures++; $display("FAIL fresh_value[%0d]: got %0d want %0d", j, outs[j], exp_out[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 2; v++) begin
            fill_random();
            build_model();
            run_vector(N, 0, 1'b0, -1);
            checks++; if (timed_out || seq_err != 0 || outs.size() != M) begin
                failures++; $display("FAIL b2b_protocol[%0d]: timeout=%0d seq_err=%0d outputs=%0d want 0/0/%0d", v, timed_out, seq_err, outs.size(), M);
            end
            for (int j = 0; j < outs.size() && j < M; j++) begin
                checks++; if (outs[j] != exp_out[j]) begin
                    failures++; $display("FAIL b2b_value[%0d][%0d]: got %0d want %0d", v, j, outs[j], exp_out[j]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed_sum();
        test_saturation();
        test_gapped_random();
        test_ignore_during_compute();
        test_reset_mid_drain();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
